// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// UART transceiver with independent TX and RX FIFOs and valid/ready
// streaming on the byte side. The TX and RX serial engines live in this one
// module. Received frames are checked for parity and stop-bit errors, which
// are recorded in sticky status flags.
//
// Ports
//   clock_i, reset_n_i      system clock, synchronous active-low reset
//   clock_divider_i         clock_i cycles per serial bit (>= 4)
//   two_stop_bits_i         TX sends two stop bits when high
//   parity_bit_i            frame carries a parity bit
//   parity_even_i           even parity when high, odd when low
//   serial_i / serial_o     RX pin (asynchronous) / TX pin
//   tx_data_i, tx_valid_i, tx_ready_o   TX byte stream in
//   rx_data_o, rx_valid_o, rx_ready_i   RX byte stream out
//   tx_idle_o               TX FIFO empty and TX engine idle
//   parity_error_o, frame_error_o, overrun_o   sticky receive status
//   clear_errors_i          clears the sticky flags
//
// Optional feature (macro UART_FIFO_LOOPBACK_EN)
//   Adds input loopback_i. When high, the RX synchronizer is fed from the
//   internal TX output and serial_o is held at 1.
// ---------------------------------------------------------------------------
module uart_fifo #(
    parameter int CLOCK_DIVIDER_WIDTH = 16,
    parameter int DATA_BITS           = 8,
    parameter int TX_DEPTH            = 4,
    parameter int RX_DEPTH            = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic                           two_stop_bits_i,
    input  logic                           parity_bit_i,
    input  logic                           parity_even_i,
`ifdef UART_FIFO_LOOPBACK_EN
    input  logic                           loopback_i,
`endif
    input  logic                           serial_i,
    output logic                           serial_o,
    input  logic [DATA_BITS-1:0]           tx_data_i,
    input  logic                           tx_valid_i,
    output logic                           tx_ready_o,
    output logic [DATA_BITS-1:0]           rx_data_o,
    output logic                           rx_valid_o,
    input  logic                           rx_ready_i,
    output logic                           tx_idle_o,
    output logic                           parity_error_o,
    output logic                           frame_error_o,
    output logic                           overrun_o,
    input  logic                           clear_errors_i
);

    localparam int CW    = CLOCK_DIVIDER_WIDTH;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    localparam logic [CW-1:0]    CNT_ONE  = 1;
    localparam logic [TX_AW:0]   TX_ONE   = 1;
    localparam logic [RX_AW:0]   RX_ONE   = 1;
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rxState_t;

    // Shared bit-timing compare values
    logic [CW-1:0] divMinus1;
    logic [CW-1:0] halfMinus1;
    assign divMinus1  = clock_divider_i - CNT_ONE;
    assign halfMinus1 = (clock_divider_i >> 1) - CNT_ONE;

    // -----------------------------------------------------------------------
    // TX FIFO
    // -----------------------------------------------------------------------
    logic [DATA_BITS-1:0] txMem_q [TX_DEPTH];
    logic [TX_AW:0]       txWptr_q, txRptr_q, txWptr_d, txRptr_d;
    logic                 txReady_q;
    logic                 txPush, txPop, txEmpty, txFull_d;
    logic [DATA_BITS-1:0] txHead;

    assign txEmpty  = (txWptr_q == txRptr_q);
    assign txPush   = tx_valid_i && txReady_q;
    assign txHead   = txMem_q[txRptr_q[TX_AW-1:0]];
    assign txWptr_d = txPush ? txWptr_q + TX_ONE : txWptr_q;
    assign txRptr_d = txPop  ? txRptr_q + TX_ONE : txRptr_q;
    // The extra pointer bit distinguishes full from empty when indices match
    assign txFull_d = (txWptr_d[TX_AW] != txRptr_d[TX_AW]) &&
                      (txWptr_d[TX_AW-1:0] == txRptr_d[TX_AW-1:0]);

    // TX FIFO storage and pointers; tx_ready_o is registered from next occupancy
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            txWptr_q  <= '0;
            txRptr_q  <= '0;
            txReady_q <= 1'b1;
        end else begin
            if (txPush) begin
                txMem_q[txWptr_q[TX_AW-1:0]] <= tx_data_i;
            end
            txWptr_q  <= txWptr_d;
            txRptr_q  <= txRptr_d;
            txReady_q <= !txFull_d;
        end
    end

    // -----------------------------------------------------------------------
    // TX engine
    // -----------------------------------------------------------------------
    txState_t             txState_q;
    logic [CW-1:0]        txCnt_q;
    logic [DATA_BITS-1:0] txShift_q;
    logic [3:0]           txBitIdx_q;
    logic                 txSerial_q;
    logic                 txParity_q, txParityEn_q, txTwoStop_q;
    logic                 txBitEnd, txFrameEnd;

    assign txBitEnd   = (txCnt_q == divMinus1);
    assign txFrameEnd = txBitEnd &&
                        ((txState_q == TX_STOP1 && !txTwoStop_q) || txState_q == TX_STOP2);
    // Popping at the end of the last stop bit gives back-to-back frames
    assign txPop      = !txEmpty && (txState_q == TX_IDLE || txFrameEnd);

    // TX state machine: loads a byte and the frame format on each pop, then
    // walks the frame one bit period per state with a registered line output
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            txState_q    <= TX_IDLE;
            txCnt_q      <= '0;
            txShift_q    <= '0;
            txBitIdx_q   <= '0;
            txSerial_q   <= 1'b1;
            txParity_q   <= 1'b0;
            txParityEn_q <= 1'b0;
            txTwoStop_q  <= 1'b0;
        end else if (txPop) begin
            txState_q    <= TX_START;
            txCnt_q      <= '0;
            txSerial_q   <= 1'b0;
            txShift_q    <= txHead;
            txParity_q   <= (^txHead) ^ ~parity_even_i;
            txParityEn_q <= parity_bit_i;
            txTwoStop_q  <= two_stop_bits_i;
        end else if (txState_q != TX_IDLE) begin
            if (!txBitEnd) begin
                txCnt_q <= txCnt_q + CNT_ONE;
            end else begin
                txCnt_q <= '0;
                case (txState_q)
                    TX_START: begin
                        txState_q  <= TX_DATA;
                        txSerial_q <= txShift_q[0];
                        txShift_q  <= txShift_q >> 1;
                        txBitIdx_q <= '0;
                    end
                    TX_DATA: begin
                        if (txBitIdx_q == LAST_BIT) begin
                            if (txParityEn_q) begin
                                txState_q  <= TX_PARITY;
                                txSerial_q <= txParity_q;
                            end else begin
                                txState_q  <= TX_STOP1;
                                txSerial_q <= 1'b1;
                            end
                        end else begin
                            txSerial_q <= txShift_q[0];
                            txShift_q  <= txShift_q >> 1;
                            txBitIdx_q <= txBitIdx_q + 4'd1;
                        end
                    end
                    TX_PARITY: begin
                        txState_q  <= TX_STOP1;
                        txSerial_q <= 1'b1;
                    end
                    TX_STOP1: begin
                        txState_q  <= txTwoStop_q ? TX_STOP2 : TX_IDLE;
                        txSerial_q <= 1'b1;
                    end
                    default: begin
                        txState_q  <= TX_IDLE;
                        txSerial_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_ready_o = txReady_q;
    assign tx_idle_o  = txEmpty && (txState_q == TX_IDLE);

    // Pin routing, optionally looping TX back into RX
    logic rxLineIn;
`ifdef UART_FIFO_LOOPBACK_EN
    assign serial_o = loopback_i ? 1'b1 : txSerial_q;
    assign rxLineIn = loopback_i ? txSerial_q : serial_i;
`else
    assign serial_o = txSerial_q;
    assign rxLineIn = serial_i;
`endif

    // -----------------------------------------------------------------------
    // RX synchronizer and engine
    // -----------------------------------------------------------------------
    logic rxSync1_q, rxSync2_q, rxPrev_q;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
            rxPrev_q  <= 1'b1;
        end else begin
            rxSync1_q <= rxLineIn;
            rxSync2_q <= rxSync1_q;
            rxPrev_q  <= rxSync2_q;
        end
    end

    rxState_t             rxState_q;
    logic [CW-1:0]        rxCnt_q;
    logic [DATA_BITS-1:0] rxShift_q;
    logic [3:0]           rxBitIdx_q;
    logic                 rxParityEn_q, rxParityEven_q, rxParBit_q;
    logic                 rxPushReq_q, rxParErrPend_q, rxFrameErrPend_q;
    logic                 rxBitEnd;

    assign rxBitEnd = (rxCnt_q == divMinus1);

    // RX state machine: half-bit wait from the falling edge, then one sample
    // per bit period at mid-bit. The stop sample raises a one-cycle push
    // request carrying the frame's error status.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            rxState_q        <= RX_IDLE;
            rxCnt_q          <= '0;
            rxShift_q        <= '0;
            rxBitIdx_q       <= '0;
            rxParityEn_q     <= 1'b0;
            rxParityEven_q   <= 1'b0;
            rxParBit_q       <= 1'b0;
            rxPushReq_q      <= 1'b0;
            rxParErrPend_q   <= 1'b0;
            rxFrameErrPend_q <= 1'b0;
        end else begin
            rxPushReq_q <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    if (rxPrev_q && !rxSync2_q) begin
                        rxState_q      <= RX_START;
                        rxCnt_q        <= '0;
                        rxParityEn_q   <= parity_bit_i;
                        rxParityEven_q <= parity_even_i;
                    end
                end
                RX_START: begin
                    if (rxCnt_q == halfMinus1) begin
                        rxCnt_q    <= '0;
                        rxBitIdx_q <= '0;
                        // A line back high at mid start bit was only a glitch
                        rxState_q  <= rxSync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rxBitEnd) begin
                        rxCnt_q   <= '0;
                        rxShift_q <= {rxSync2_q, rxShift_q[DATA_BITS-1:1]};
                        if (rxBitIdx_q == LAST_BIT) begin
                            rxState_q <= rxParityEn_q ? RX_PARITY : RX_STOP;
                        end else begin
                            rxBitIdx_q <= rxBitIdx_q + 4'd1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_ONE;
                    end
                end
                RX_PARITY: begin
                    if (rxBitEnd) begin
                        rxCnt_q    <= '0;
                        rxParBit_q <= rxSync2_q;
                        rxState_q  <= RX_STOP;
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rxBitEnd) begin
                        rxCnt_q          <= '0;
                        rxPushReq_q      <= 1'b1;
                        rxParErrPend_q   <= rxParityEn_q &&
                                            ((^rxShift_q) ^ rxParBit_q ^ ~rxParityEven_q);
                        rxFrameErrPend_q <= !rxSync2_q;
                        // A low stop bit must clear before a new start edge counts
                        rxState_q        <= rxSync2_q ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_ONE;
                    end
                end
                default: begin
                    if (rxSync2_q) begin
                        rxState_q <= RX_IDLE;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // RX FIFO and sticky flags
    // -----------------------------------------------------------------------
    logic [DATA_BITS-1:0] rxMem_q [RX_DEPTH];
    logic [RX_AW:0]       rxWptr_q, rxRptr_q, rxWptr_d, rxRptr_d;
    logic                 rxValid_q;
    logic                 rxPush, rxPop, rxFull;
    logic                 parityError_q, frameError_q, overrun_q;

    assign rxPop    = rxValid_q && rx_ready_i;
    assign rxFull   = (rxWptr_q[RX_AW] != rxRptr_q[RX_AW]) &&
                      (rxWptr_q[RX_AW-1:0] == rxRptr_q[RX_AW-1:0]);
    // A pop in the same cycle frees the slot a full FIFO needs
    assign rxPush   = rxPushReq_q && (!rxFull || rxPop);
    assign rxWptr_d = rxPush ? rxWptr_q + RX_ONE : rxWptr_q;
    assign rxRptr_d = rxPop  ? rxRptr_q + RX_ONE : rxRptr_q;

    // RX FIFO storage and pointers; rx_valid_o is registered from next occupancy
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                rxMem_q[i] <= '0;
            end
            rxWptr_q  <= '0;
            rxRptr_q  <= '0;
            rxValid_q <= 1'b0;
        end else begin
            if (rxPush) begin
                rxMem_q[rxWptr_q[RX_AW-1:0]] <= rxShift_q;
            end
            rxWptr_q  <= rxWptr_d;
            rxRptr_q  <= rxRptr_d;
            rxValid_q <= (rxWptr_d != rxRptr_d);
        end
    end

    // Sticky error flags; a set event takes priority over a clear request
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            parityError_q <= 1'b0;
            frameError_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (rxPushReq_q && rxParErrPend_q) begin
                parityError_q <= 1'b1;
            end else if (clear_errors_i) begin
                parityError_q <= 1'b0;
            end
            if (rxPushReq_q && rxFrameErrPend_q) begin
                frameError_q <= 1'b1;
            end else if (clear_errors_i) begin
                frameError_q <= 1'b0;
            end
            if (rxPushReq_q && !rxPush) begin
                overrun_q <= 1'b1;
            end else if (clear_errors_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_data_o      = rxMem_q[rxRptr_q[RX_AW-1:0]];
    assign rx_valid_o     = rxValid_q;
    assign parity_error_o = parityError_q;
    assign frame_error_o  = frameError_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_uart_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo
// Directed bench for uart_fifo: TX bit timing, TX FIFO backpressure and
// ordering, RX parity/frame/glitch/overrun handling, mid-frame reset and,
// when UART_FIFO_LOOPBACK_EN is defined, internal loopback.
// ---------------------------------------------------------------------------
module tb_uart_fifo;

    logic        clock_i;
    logic        reset_n_i;
    logic [15:0] clock_divider_i;
    logic        two_stop_bits_i;
    logic        parity_bit_i;
    logic        parity_even_i;
    logic        serial_i;
    logic        serial_o;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        tx_idle_o;
    logic        parity_error_o;
    logic        frame_error_o;
    logic        overrun_o;
    logic        clear_errors_i;
`ifdef UART_FIFO_LOOPBACK_EN
    logic        loopback_i;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic       monEnable = 1'b0;
    logic [7:0] txBytes[$];

    uart_fifo dut (
        .clock_i         (clock_i),
        .reset_n_i       (reset_n_i),
        .clock_divider_i (clock_divider_i),
        .two_stop_bits_i (two_stop_bits_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
`ifdef UART_FIFO_LOOPBACK_EN
        .loopback_i      (loopback_i),
`endif
        .serial_i        (serial_i),
        .serial_o        (serial_o),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .tx_idle_o       (tx_idle_o),
        .parity_error_o  (parity_error_o),
        .frame_error_o   (frame_error_o),
        .overrun_o       (overrun_o),
        .clear_errors_i  (clear_errors_i)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Serial monitor: decodes 8N1 frames on serial_o into txBytes, sampling
    // each bit at its middle relative to the first low cycle of the start bit
    initial begin : txMonitor
        logic [7:0] b;
        forever begin
            @(negedge clock_i);
            if (monEnable && serial_o === 1'b0) begin
                repeat (clock_divider_i / 2) @(negedge clock_i);
                for (int k = 0; k < 8; k++) begin
                    repeat (clock_divider_i) @(negedge clock_i);
                    b[k] = serial_o;
                end
                repeat (clock_divider_i) @(negedge clock_i);
                txBytes.push_back(b);
            end
        end
    end

    // One comparison: counts it, and reports and counts a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one RX frame on serial_i (LSB first), leaving the line high
    task automatic applyStimulus(input logic [7:0] data, input logic parityOn,
                                 input logic parityVal, input logic stopVal);
        serial_i = 1'b0;
        repeat (clock_divider_i) @(negedge clock_i);
        for (int k = 0; k < 8; k++) begin
            serial_i = data[k];
            repeat (clock_divider_i) @(negedge clock_i);
        end
        if (parityOn) begin
            serial_i = parityVal;
            repeat (clock_divider_i) @(negedge clock_i);
        end
        serial_i = stopVal;
        repeat (clock_divider_i) @(negedge clock_i);
        serial_i = 1'b1;
    endtask

    // Presents one byte on the TX stream for a single cycle
    task automatic pushTx(input logic [7:0] data);
        tx_data_i  = data;
        tx_valid_i = 1'b1;
        @(negedge clock_i);
        tx_valid_i = 1'b0;
    endtask

    // Pops the RX FIFO head for a single cycle
    task automatic popRx();
        rx_ready_i = 1'b1;
        @(negedge clock_i);
        rx_ready_i = 1'b0;
    endtask

    // Directed test sequence
    initial begin : stimulus
        logic [9:0] expBits;
        logic [7:0] expBytes [5];
        int         waited;

        reset_n_i       = 1'b0;
        clock_divider_i = 16'd4;
        two_stop_bits_i = 1'b0;
        parity_bit_i    = 1'b0;
        parity_even_i   = 1'b1;
        serial_i        = 1'b1;
        tx_data_i       = 8'h00;
        tx_valid_i      = 1'b0;
        rx_ready_i      = 1'b0;
        clear_errors_i  = 1'b0;
`ifdef UART_FIFO_LOOPBACK_EN
        loopback_i      = 1'b0;
`endif

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock_i);
        checkOutput("rstSerial", serial_o, 1);
        checkOutput("rstTxReady", tx_ready_o, 1);
        checkOutput("rstRxValid", rx_valid_o, 0);
        checkOutput("rstTxIdle", tx_idle_o, 1);
        checkOutput("rstParErr", parity_error_o, 0);
        checkOutput("rstFrmErr", frame_error_o, 0);
        checkOutput("rstOverrun", overrun_o, 0);
        checkOutput("rstRxData", rx_data_o, 8'h00);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clock_i);

        // ---------------- basic TX, 0xA5 8N1, divider 4 ----------------
        // wire order: start 0, data 1,0,1,0,0,1,0,1, stop 1 (index 0 first)
        expBits = 10'b1_1010_0101_0;
        pushTx(8'hA5);
        waited = 0;
        while (serial_o !== 1'b0 && waited < 20) begin
            @(negedge clock_i);
            waited++;
        end
        checkOutput("txStartSeen", serial_o, 0);
        for (int off = 0; off < 40; off++) begin
            checkOutput($sformatf("txBit%0d_off%0d", off / 4, off), serial_o, expBits[off / 4]);
            @(negedge clock_i);
        end
        checkOutput("txIdleAfterStop", tx_idle_o, 1);
        checkOutput("txLineHighAfterStop", serial_o, 1);

        // ---------------- TX FIFO full and ordering ----------------
        txBytes.delete();
        monEnable = 1'b1;
        pushTx(8'h01);
        @(negedge clock_i);
        checkOutput("txBusy", tx_idle_o, 0);
        for (int i = 2; i <= 5; i++) begin
            checkOutput($sformatf("txReadyBefore%0d", i), tx_ready_o, 1);
            pushTx(8'(i));
        end
        checkOutput("txReadyFull", tx_ready_o, 0);
        waited = 0;
        while (tx_ready_o !== 1'b1 && waited < 100) begin
            @(negedge clock_i);
            waited++;
        end
        checkOutput("txReadyAfterPop", tx_ready_o, 1);
        waited = 0;
        while (txBytes.size() < 5 && waited < 400) begin
            @(negedge clock_i);
            waited++;
        end
        checkOutput("txStreamCount", txBytes.size(), 5);
        for (int i = 0; i < 5 && i < txBytes.size(); i++) begin
            checkOutput($sformatf("txStream%0d", i), txBytes[i], i + 1);
        end
        repeat (8) @(negedge clock_i);
        checkOutput("txIdleAfterStream", tx_idle_o, 1);
        monEnable = 1'b0;

        // ---------------- RX with even parity, divider 8 ----------------
        clock_divider_i = 16'd8;
        parity_bit_i    = 1'b1;
        parity_even_i   = 1'b1;
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clock_i);
        checkOutput("rxParOkValid", rx_valid_o, 1);
        checkOutput("rxParOkData", rx_data_o, 8'h3C);
        checkOutput("rxParOkParErr", parity_error_o, 0);
        checkOutput("rxParOkFrmErr", frame_error_o, 0);
        popRx();
        checkOutput("rxParOkEmpty", rx_valid_o, 0);

        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clock_i);
        checkOutput("rxParBadValid", rx_valid_o, 1);
        checkOutput("rxParBadData", rx_data_o, 8'h3C);
        checkOutput("rxParBadParErr", parity_error_o, 1);
        checkOutput("rxParBadFrmErr", frame_error_o, 0);
        popRx();
        clear_errors_i = 1'b1;
        @(negedge clock_i);
        clear_errors_i = 1'b0;
        checkOutput("rxParErrCleared", parity_error_o, 0);

        // ---------------- frame error, 8N1 ----------------
        parity_bit_i = 1'b0;
        applyStimulus(8'h96, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clock_i);
        checkOutput("rxFrmErrFlag", frame_error_o, 1);
        checkOutput("rxFrmErrValid", rx_valid_o, 1);
        checkOutput("rxFrmErrData", rx_data_o, 8'h96);
        checkOutput("rxFrmErrParErr", parity_error_o, 0);
        popRx();
        clear_errors_i = 1'b1;
        @(negedge clock_i);
        clear_errors_i = 1'b0;
        checkOutput("rxFrmErrCleared", frame_error_o, 0);

        // ---------------- glitch, then a good frame ----------------
        serial_i = 1'b0;
        repeat (2) @(negedge clock_i);
        serial_i = 1'b1;
        repeat (30) @(negedge clock_i);
        checkOutput("rxGlitchNoValid", rx_valid_o, 0);
        checkOutput("rxGlitchNoFrmErr", frame_error_o, 0);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clock_i);
        checkOutput("rxAfterGlitchValid", rx_valid_o, 1);
        checkOutput("rxAfterGlitchData", rx_data_o, 8'h5A);
        popRx();

        // ---------------- RX overrun ----------------
        expBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(expBytes[i], 1'b0, 1'b0, 1'b1);
        end
        repeat (4) @(negedge clock_i);
        checkOutput("ovrFourValid", rx_valid_o, 1);
        checkOutput("ovrFourNoFlag", overrun_o, 0);
        checkOutput("ovrFourHead", rx_data_o, 8'h11);
        applyStimulus(expBytes[4], 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clock_i);
        checkOutput("ovrFlag", overrun_o, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovrData%0d", i), rx_data_o, expBytes[i]);
            popRx();
        end
        checkOutput("ovrDrained", rx_valid_o, 0);
        clear_errors_i = 1'b1;
        @(negedge clock_i);
        clear_errors_i = 1'b0;
        checkOutput("ovrCleared", overrun_o, 0);

`ifdef UART_FIFO_LOOPBACK_EN
        // ---------------- loopback ----------------
        begin
            logic sawLow;
            clock_divider_i = 16'd4;
            loopback_i      = 1'b1;
            sawLow          = 1'b0;
            pushTx(8'h5A);
            waited = 0;
            while (rx_valid_o !== 1'b1 && waited < 100) begin
                if (serial_o !== 1'b1) sawLow = 1'b1;
                @(negedge clock_i);
                waited++;
            end
            checkOutput("loopValid", rx_valid_o, 1);
            checkOutput("loopData", rx_data_o, 8'h5A);
            checkOutput("loopPinHigh", sawLow, 0);
            popRx();
            repeat (4) @(negedge clock_i);
            loopback_i = 1'b0;
        end
`endif

        // ---------------- reset mid TX frame ----------------
        clock_divider_i = 16'd4;
        pushTx(8'h00);
        pushTx(8'h7F);
        waited = 0;
        while (serial_o !== 1'b0 && waited < 20) begin
            @(negedge clock_i);
            waited++;
        end
        repeat (10) @(negedge clock_i);
        checkOutput("midFrameLow", serial_o, 0);
        reset_n_i = 1'b0;
        @(negedge clock_i);
        checkOutput("midRstSerial", serial_o, 1);
        checkOutput("midRstTxReady", tx_ready_o, 1);
        checkOutput("midRstTxIdle", tx_idle_o, 1);
        checkOutput("midRstRxValid", rx_valid_o, 0);
        reset_n_i = 1'b1;
        repeat (6) @(negedge clock_i);
        checkOutput("postRstSerial", serial_o, 1);
        checkOutput("postRstTxIdle", tx_idle_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
